status_flags_unit: RTL

//  Registered processor status unit generalising the Z/N/C/V status register: flags update only on valid
//  ALU/multiply results and hold otherwise, plus a sticky-overflow bit and a LIFO flag stack for

---
 rtl/status_flags_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/status_flags_unit.sv
// ============================================================================
//  Module   : status_flags_unit
//  Purpose  : Z/N/C/V status register with sticky overflow and a LIFO flag stack
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module status_flags_unit #(
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 4,
   parameter int SP_W        = 3
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              valid_i,
   input  logic [3:0]        opc_i,
   input  logic [DATA_W:0]   alu_ans_i,
   input  logic              alu_ovf_i,
   input  logic [DATA_W-1:0] hi_ans_i,
   input  logic [DATA_W-1:0] lo_ans_i,
   input  logic              sr_wr_en_i,
   input  logic [15:0]       sr_wr_data_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              clr_sticky_i,
   output logic [15:0]       sr_out_o,
   output logic [SP_W-1:0]   stk_level_o,
   output logic              stk_full_o,
   output logic              stk_empty_o
);

   // flags_q = {SV, Z, N, C, V}
   logic [4:0]      flags_q, flags_d;
   logic            err_q, err_d;
   logic [SP_W-1:0] level_q, level_d;
   logic [4:0]      stk_q [STACK_DEPTH];

   logic            full_w, empty_w, push_ok_w, pop_ok_w, err_w, upd_en_w;
   logic [4:0]      pop_data_w;
   logic            z_w, n_w, c_w, v_w;
   logic [DATA_W-1:0] res_w;
   logic            unused_wr_bits;

   assign unused_wr_bits = ^sr_wr_data_i[15:5];

   assign full_w    = (level_q == SP_W'(STACK_DEPTH));
   assign empty_w   = (level_q == '0);
   assign push_ok_w = push_i && !pop_i && !full_w;
   assign pop_ok_w  = pop_i && !push_i && !empty_w;
   assign err_w     = (push_i && pop_i) || (push_i && !pop_i && full_w)
                    || (pop_i && !push_i && empty_w);
   assign res_w     = alu_ans_i[DATA_W-1:0];
   assign upd_en_w  = valid_i && ((opc_i <= 4'd5) || (opc_i == 4'd10));

   always_comb begin
      pop_data_w = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (level_q - SP_W'(1) == SP_W'(i)) pop_data_w = stk_q[i];
      end
   end

   always_comb begin
      z_w = flags_q[3];
      n_w = flags_q[2];
      c_w = flags_q[1];
      v_w = flags_q[0];
      if (opc_i <= 4'd5) begin
         z_w = (res_w == '0);
         n_w = res_w[DATA_W-1];
         v_w = alu_ovf_i;
         if (opc_i <= 4'd1) c_w = alu_ans_i[DATA_W];
      end else if (opc_i == 4'd10) begin
         z_w = (hi_ans_i == '0) && (lo_ans_i == '0);
         n_w = hi_ans_i[DATA_W-1];
         v_w = (hi_ans_i != {DATA_W{lo_ans_i[DATA_W-1]}});
      end
   end

   // Flag write priority: software write, then pop restore, then result update
   always_comb begin
      flags_d    = flags_q;
      flags_d[4] = clr_sticky_i ? 1'b0 : flags_q[4];
      if (sr_wr_en_i) begin
         flags_d = sr_wr_data_i[4:0];
      end else if (pop_ok_w) begin
         flags_d = pop_data_w;
      end else if (upd_en_w) begin
         flags_d[3:0] = {z_w, n_w, c_w, v_w};
         if (v_w) flags_d[4] = 1'b1;
      end
      err_d   = err_w || (err_q && !clr_sticky_i);
      level_d = level_q;
      if (push_ok_w)     level_d = level_q + SP_W'(1);
      else if (pop_ok_w) level_d = level_q - SP_W'(1);
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         flags_q <= '0;
         err_q   <= 1'b0;
         level_q <= '0;
      end else begin
         flags_q <= flags_d;
         err_q   <= err_d;
         level_q <= level_d;
      end
   end

   // Stack storage needs no reset: the level counter defines which entries are live
   always_ff @(posedge clock_i) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (push_ok_w && (level_q == SP_W'(i))) stk_q[i] <= flags_q;
      end
   end

   assign sr_out_o    = {10'b0, err_q, flags_q};
   assign stk_level_o = level_q;
   assign stk_full_o  = full_w;
   assign stk_empty_o = empty_w;

endmodule

`default_nettype wire
